// File: rtl/debounce_bank.sv
// Multi-channel input debouncer: synchronises each raw input, requires it to stay
// stable for TIMER_INIT cycles before updating dataOut, and reports edges and sticky change flags.
module debounce_bank #(
    parameter int                     CHANNELS    = 8,
    parameter int                     TIMER_WIDTH = 16,
    parameter logic [TIMER_WIDTH-1:0] TIMER_INIT  = 16'd50000,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0]    RESET_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] dataIn,
    output logic [CHANNELS-1:0] dataOut,
    output logic [CHANNELS-1:0] risePulse,
    output logic [CHANNELS-1:0] fallPulse,
    output logic [CHANNELS-1:0] changedMask,
    input  logic                ack,
    output logic                irq
);

    logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    p;
    logic [TIMER_WIDTH-1:0] timer [CHANNELS];
    logic [CHANNELS-1:0]    reload;
    logic [CHANNELS-1:0]    transfer;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= dataIn;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A channel transfers on the expiry edge even if a fresh toggle reloads its timer there.
    always_comb begin
        reload   = '0;
        transfer = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            reload[i]   = (s[i] != p[i]);
            transfer[i] = (timer[i] == '0) && (p[i] != dataOut[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p           <= RESET_VALUE;
            dataOut     <= RESET_VALUE;
            risePulse   <= '0;
            fallPulse   <= '0;
            changedMask <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                timer[i] <= TIMER_INIT;
            end
        end else begin
            p           <= s;
            dataOut     <= (dataOut & ~transfer) | (p & transfer);
            risePulse   <= transfer & p;
            fallPulse   <= transfer & ~p;
            changedMask <= (ack ? '0 : changedMask) | transfer;
            for (int i = 0; i < CHANNELS; i++) begin
                if (reload[i]) begin
                    timer[i] <= TIMER_INIT;
                end else if (timer[i] != '0) begin
                    timer[i] <= timer[i] - TIMER_WIDTH'(1);
                end
            end
        end
    end

    assign irq = |changedMask;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent input channels (>=1).
REQ-002 SHALL have parameter TIMER_WIDTH, default 16: per-channel timer width in bits.
REQ-003 SHALL have parameter TIMER_INIT, default 16'd50000: timer load value, 0..2^TIMER_WIDTH-1.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (>=2).
REQ-005 SHALL have parameter RESET_VALUE, default all-zero: CHANNELS-bit reset state of synchronisers and dataOut.
REQ-006 SHALL have port clock, input, 1: system clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port dataIn, input, CHANNELS: asynchronous raw inputs, one per channel.
REQ-009 SHALL have port dataOut, output, CHANNELS: registered debounced values.
REQ-010 SHALL have port risePulse, output, CHANNELS: one-cycle pulse when the matching dataOut bit goes 0->1.
REQ-011 SHALL have port fallPulse, output, CHANNELS: one-cycle pulse when the matching dataOut bit goes 1->0.
REQ-012 SHALL have port changedMask, output, CHANNELS: sticky per-channel change flags.
REQ-013 SHALL have port ack, input, 1: clears changedMask.
REQ-014 SHALL have port irq, output, 1: OR-reduction of changedMask, registered or combinational from the registered mask.

Function
REQ-015 Each channel SHALL pass dataIn through SYNC_STAGES flops; the last stage is s[i]; p[i] SHALL hold s[i] delayed one cycle.
REQ-016 At each edge where s[i] != p[i], timer[i] SHALL load TIMER_INIT.
REQ-017 Otherwise timer[i] SHALL decrement by 1 if nonzero and saturate at 0 (no wrap).
REQ-018 At each edge where timer[i] == 0 (pre-edge value) and p[i] != dataOut[i], dataOut[i] SHALL take p[i]; otherwise it holds.
REQ-019 Latency SHALL be fixed: a dataIn change before edge 1 that stays stable updates dataOut at edge SYNC_STAGES+TIMER_INIT+2.
REQ-020 Any input toggle seen at s within TIMER_INIT cycles of the previous toggle SHALL reload the timer and leave dataOut unchanged.
REQ-021 A toggle seen at the edge where the pre-edge timer is 0 SHALL still let that edge's transfer occur; the timer still reloads.
REQ-022 TIMER_INIT = 0 SHALL be legal: dataOut follows p with one extra cycle and no filtering.
REQ-023 risePulse[i]/fallPulse[i] SHALL be registered, asserted only in the cycle after the edge that changed dataOut[i], and high for exactly one cycle per change.
REQ-024 risePulse[i] and fallPulse[i] SHALL never be high in the same cycle.
REQ-025 changedMask[i] SHALL set at any edge that changes dataOut[i].
REQ-026 changedMask SHALL clear, all bits, at an edge with ack=1.
REQ-027 If ack=1 at the same edge that changes dataOut[i], bit i SHALL end set (set wins); other bits clear.
REQ-028 Channels SHALL be fully independent; no cross-channel interaction except irq and ack.

Reset
REQ-029 At an edge with reset=1: synchroniser flops, p and dataOut SHALL load RESET_VALUE; every timer SHALL load TIMER_INIT; risePulse, fallPulse, changedMask and irq SHALL be 0.
REQ-030 Reset SHALL override every other update in the same cycle, including ack and pending transfers; mid-countdown progress is discarded.
REQ-031 After reset deassertion, no dataOut change SHALL occur before the timer counts down from TIMER_INIT.

Verification (CHANNELS=4, TIMER_WIDTH=4, TIMER_INIT=3, SYNC_STAGES=2, RESET_VALUE=0)
V-1 Reset, hold dataIn=0000 for 20 cycles -> dataOut=0000, no pulses, changedMask=0000, irq=0.
V-2 dataIn[0] 0->1 before edge 1, held -> dataOut[0]=1 after edge 7; risePulse[0]=1 for exactly the one following cycle; changedMask=0001, irq=1.
V-3 dataIn[1] high for 2 cycles, then low -> dataOut[1] stays 0, no pulse, changedMask unchanged.
V-4 After V-2, pulse ack one cycle -> changedMask=0000, irq=0; repeat with ack on the dataOut[0] fall edge -> fallPulse[0]=1, changedMask[0]=1.
V-5 dataIn=1010 at once -> bits 1 and 3 rise together after edge 7; bits 0 and 2 unaffected.
V-6 Assert reset 2 cycles after the V-2 toggle -> dataOut=0000, no pulse; with dataIn still 0001, dataOut[0] rises 3+SYNC_STAGES+2 edges after reset release.
